// File: rtl/simon_pkg.sv
// Shared SIMON32/64 definitions: widths, round count, z0 sequence, FSM states.
package simon_pkg;

  localparam int unsigned N  = 16;
  localparam int unsigned M  = 4;
  localparam int unsigned T  = 32;
  localparam int unsigned RW = 5;

  localparam logic [61:0] Z = 62'b11111010001001010110000111001101111101000100101011000011100110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Character j (from the left) of z0 lives at vector bit 61-j.
  function automatic logic z_bit(input logic [RW-1:0] round);
    logic [5:0] idx;
    idx = 6'd61 - {1'b0, round};
    return Z[idx];
  endfunction

  function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input int unsigned s);
    return (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] rotr(input logic [N-1:0] v, input int unsigned s);
    return (v >> s) | (v << (N - s));
  endfunction

endpackage

// File: rtl/simon_round.sv
// One SIMON32/64 Feistel round plus the matching key-schedule step (combinational).
module simon_round
  import simon_pkg::*;
(
  input  logic [N-1:0]  i_x,
  input  logic [N-1:0]  i_y,
  input  logic [N-1:0]  i_rk0,
  input  logic [N-1:0]  i_rk1,
  input  logic [N-1:0]  i_rk2,
  input  logic [N-1:0]  i_rk3,
  input  logic [RW-1:0] i_round,
  output logic [N-1:0]  o_x,
  output logic [N-1:0]  o_y,
  output logic [N-1:0]  o_k_new
);

  logic [N-1:0] w_f;
  logic [N-1:0] w_tmp;

  always_comb begin
    w_f     = (rotl(i_x, 1) & rotl(i_x, 8)) ^ rotl(i_x, 2);
    o_x     = i_y ^ w_f ^ i_rk0;
    o_y     = i_x;
    // rk2 is not consumed for m=4, but stays on the port for the shared window shape
    w_tmp   = rotr(i_rk3, 3) ^ i_rk1 ^ (i_rk2 & '0);
    o_k_new = ~i_rk0 ^ w_tmp ^ rotr(w_tmp, 1)
              ^ {{(N-1){1'b0}}, z_bit(i_round)}
              ^ {{(N-2){1'b0}}, 2'b11};
  end

endmodule

// File: rtl/simon_encrypt_core.sv
// Iterative SIMON32/64 encryptor: one round per clock, rolling 4-word key window.
module simon_encrypt_core
  import simon_pkg::*;
(
  input  logic             clk,
  input  logic             nR,
  input  logic             newKEY,
  input  logic [M*N-1:0]   KEY,
  output logic             loadKEY,
  input  logic             newDATA,
  input  logic [2*N-1:0]   inDATA,
  output logic             loadDATA,
  output logic [2*N-1:0]   outDATA,
  output logic             newOUT,
  input  logic             outLOAD,
  output logic             busy
);

  state_t          r_state;
  logic [N-1:0]    r_x;
  logic [N-1:0]    r_y;
  logic [N-1:0]    r_rk [M];
  logic [M*N-1:0]  r_mkey;
  logic [RW-1:0]   r_round;
  logic            r_key_valid;
  logic            r_load_key;
  logic            r_load_data;
  logic [2*N-1:0]  r_out_data;
  logic            r_new_out;

  logic [N-1:0]    w_x_next;
  logic [N-1:0]    w_y_next;
  logic [N-1:0]    w_k_new;
  logic            w_key_take;
  logic            w_data_take;
  logic            w_out_write;

  simon_round u_round (
    .i_x     (r_x),
    .i_y     (r_y),
    .i_rk0   (r_rk[0]),
    .i_rk1   (r_rk[1]),
    .i_rk2   (r_rk[2]),
    .i_rk3   (r_rk[3]),
    .i_round (r_round),
    .o_x     (w_x_next),
    .o_y     (w_y_next),
    .o_k_new (w_k_new)
  );

  // A request still high during its own acknowledge cycle must not be re-served.
  always_comb begin
    w_key_take  = (r_state == IDLE) && newKEY && !r_load_key;
    w_data_take = (r_state == IDLE) && !newKEY && newDATA && r_key_valid;
    w_out_write = (r_state == DONE) && (!r_new_out || outLOAD);
  end

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_y         <= '0;
      for (int unsigned i = 0; i < M; i++) r_rk[i] <= '0;
      r_mkey      <= '0;
      r_round     <= '0;
      r_key_valid <= 1'b0;
      r_load_key  <= 1'b0;
      r_load_data <= 1'b0;
      r_out_data  <= '0;
      r_new_out   <= 1'b0;
    end else begin
      r_load_key  <= w_key_take;
      r_load_data <= w_data_take;
      if (w_key_take) begin
        r_mkey      <= KEY;
        r_key_valid <= 1'b1;
      end
      if (w_out_write) begin
        r_out_data <= {r_x, r_y};
        r_new_out  <= 1'b1;
      end else if (outLOAD) begin
        r_new_out  <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_data_take) begin
            r_x     <= inDATA[2*N-1:N];
            r_y     <= inDATA[N-1:0];
            for (int unsigned i = 0; i < M; i++) r_rk[i] <= r_mkey[i*N +: N];
            r_round <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_x <= w_x_next;
          r_y <= w_y_next;
          for (int unsigned i = 0; i < M - 1; i++) r_rk[i] <= r_rk[i+1];
          r_rk[M-1] <= w_k_new;
          if (r_round == RW'(T - 1)) r_state <= DONE;
          else                       r_round <= r_round + 1'b1;
        end
        DONE: begin
          if (w_out_write) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign loadKEY  = r_load_key;
  assign loadDATA = r_load_data;
  assign outDATA  = r_out_data;
  assign newOUT   = r_new_out;
  assign busy     = (r_state != IDLE);

endmodule

// File: doc/simon_encrypt_core.md
# simon_encrypt_core

Iterative SIMON32/64 encryption engine directly downstream of the input packet stage. It accepts round-key material and plaintext blocks through held-request/one-cycle-acknowledge handshakes, runs one Feistel round per clock with on-the-fly key expansion, and presents the ciphertext block to the output stage through the same style of handshake.

## Interface
Parameters:
- N, 16, word width in bits.
- M, 4, number of key words.
- T, 32, number of rounds.
- Z, 62-bit z0 sequence `11111010001001010110000111001101111101000100101011000011100110`; bit index j is the j-th character from the left.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- nR  input  1  reset, asynchronous and active-low.
- newKEY  input  1  key request, held until acknowledged.
- KEY  input  M×N  key words; KEY[i] = k_i.
- loadKEY  output  1  one-cycle key acknowledge.
- newDATA  input  1  plaintext request, held until acknowledged.
- inDATA  input  2×N  plaintext block; inDATA[1] = x, inDATA[0] = y.
- loadDATA  output  1  one-cycle plaintext acknowledge.
- outDATA  output  2×N  ciphertext block; outDATA[1] = x, outDATA[0] = y.
- newOUT  output  1  ciphertext valid, held until outLOAD.
- outLOAD  input  1  output-stage acknowledge pulse.
- busy  output  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, RUN, DONE. Reset values: all outputs 0; the x/y, rk[0..3], master-key and round-counter registers are 0; keyValid = 0; state = IDLE.
- IDLE, newKEY=1:
  - Master key ← KEY.
  - keyValid ← 1.
  - loadKEY pulses for one cycle.
  - Key has priority over data when both requests are pending.
- IDLE, newDATA=1, keyValid=1, no key request:
  - x ← inDATA[1], y ← inDATA[0].
  - rk[0..3] ← master key.
  - round ← 0.
  - loadDATA pulses for one cycle.
  - Next state RUN.
- newDATA with keyValid=0 is not acknowledged; the request stays pending.
- RUN, each cycle:
  - f(x) = (x⋘1 & x⋘8) ^ (x⋘2).
  - x ← y ^ f(x) ^ rk[0]; y ← x.
  - tmp = (rk[3]⋙3) ^ rk[1]; new = ~rk[0] ^ tmp ^ (tmp⋙1) ^ Z[round] ^ 3, all mod 2^N.
  - Shift rk[0] ← rk[1] ← rk[2] ← rk[3] ← new.
  - round++. When round = T−1 the round completes and the next state is DONE.
- DONE:
  - If newOUT=0 or outLOAD=1: outDATA ← {x, y}, newOUT ← 1, next state IDLE.
  - Otherwise stay in DONE, with x, y and round frozen.
- newOUT clears on any edge with outLOAD=1, except when DONE writes on that same edge; set wins.
- newKEY during RUN or DONE is not acknowledged and is served in the next IDLE. The block in flight keeps its expansion from the old key.
- A loadKEY or loadDATA pulse is never issued in the same cycle as the other.

## Timing
- Capture edge E0 (loadDATA high after E0). Rounds execute at E1..E32. Output written at E33, so newOUT rises 33 cycles after loadDATA rises when the output stage is free.
- Throughput: one block per 34 cycles. Back-to-back: the next loadDATA can occur at E34.
- loadKEY/loadDATA are registered, high for exactly one cycle. The requester drops its request on the edge after.
- nR low at any time, including mid-RUN or in DONE: immediate return to reset values. The partial block is discarded and keyValid is cleared.
- Round counter width is 5 bits; it never wraps because RUN exits at T−1.

## Structure
- Shared definitions package (simon_pkg):
  - N, M, T.
  - The Z constant.
  - The state enum typedef {IDLE, RUN, DONE}.
  - This package is shared with the input and output packet stages.
- One combinational sub-module, simon_round: takes x, y, rk[0..3], round; returns the next x, y and new key word. It is reused unchanged by a later decryption core.

## Test plan
- Standard vector: key {k3..k0} = 1918 1110 0908 0100, then plaintext x=6565 y=6877 -> loadKEY, then loadDATA; newOUT rises 33 cycles after loadDATA with x=c69b y=e9bb.
- newDATA asserted before any key -> no loadDATA for 50 cycles. Then load key -> loadKEY, then loadDATA next IDLE cycle, correct ciphertext.
- Hold outLOAD low after the first result and issue a second block -> the second block parks in DONE, busy=1, and no third loadDATA is issued. Pulse outLOAD -> the second ciphertext appears on the next edge and newOUT stays high.
- newKEY and newDATA asserted together in IDLE -> loadKEY first; loadDATA follows and the encryption uses the new key.
- New key presented at round 10 of a block -> the current ciphertext matches the old key; loadKEY follows in IDLE before the next loadDATA.
- nR pulsed low at round 15 -> all outputs 0 immediately. A subsequent data request is not acknowledged until a key is reloaded.
